// File: rtl/wind_pkg.sv
// Shared constants and types for the wind statistics path.
// Angles and bearings are 9Q7 degrees; moduli are 6Q10.
package wind_pkg;

  localparam int MOD_W    = 16;
  localparam int ANG_W    = 16;
  localparam int MOD_FRAC = 10;
  localparam int ANG_FRAC = 7;

  // One full turn and half turn in 9Q7 degrees
  localparam int DEG360_Q7 = 46080;
  localparam int DEG180_Q7 = 23040;

  typedef enum logic {
    S_EMPTY = 1'b0,  // no samples taken in the current window
    S_ACCUM = 1'b1   // at least one sample taken
  } win_state_e;

endpackage : wind_pkg

// File: rtl/wind_bearing_conv.sv
// Signed angle to compass bearing conversion (combinational).
// Ports:
//   angle_i   : signed 9Q7 degrees, range [-180, 180]
//   bearing_o : unsigned 9Q7 bearing, range [0, 360)
module wind_bearing_conv
  import wind_pkg::*;
(
  input  logic [ANG_W-1:0] angle_i,
  output logic [ANG_W-1:0] bearing_o
);

  // For negative inputs the true sum lies in [23040, 46080), so it fits
  // in ANG_W bits and modulo-2^ANG_W addition gives the exact result.
  always_comb begin
    if (angle_i[ANG_W-1]) bearing_o = angle_i + ANG_W'(DEG360_Q7);
    else                  bearing_o = angle_i;
  end

endmodule : wind_bearing_conv

// File: rtl/wind_polar_stats.sv
// Windowed wind statistics downstream of the CORDIC rect-to-polar stage.
// Over each window of 2^LOG2N accepted samples, produces the rounded mean
// modulus and the gust (peak modulus and its bearing); also tracks the
// bearing of the most recent accepted sample.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   clear         : restart the current window; held reports are kept
//   in_valid      : mod/angle valid this cycle
//   mod, angle    : signed 6Q10 modulus, signed 9Q7 angle
//   out_valid     : one-cycle pulse when the window report updates
//   avg_mod       : rounded window mean modulus (6Q10)
//   peak_mod      : window maximum modulus (6Q10)
//   peak_bearing  : bearing of the peak sample (9Q7, [0, 46080))
//   last_bearing  : bearing of the latest accepted sample (9Q7)
module wind_polar_stats
  import wind_pkg::*;
#(
  parameter int LOG2N = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [MOD_W-1:0] mod,
  input  logic signed [ANG_W-1:0] angle,
  output logic                    out_valid,
  output logic        [MOD_W-1:0] avg_mod,
  output logic        [MOD_W-1:0] peak_mod,
  output logic        [ANG_W-1:0] peak_bearing,
  output logic        [ANG_W-1:0] last_bearing
);

  // Sum of 2^LOG2N values below 2^MOD_W cannot exceed ACC_W bits, and
  // adding the rounding half still stays below 2^ACC_W.
  localparam int ACC_W = MOD_W + LOG2N;
  localparam int CNT_W = LOG2N;
  localparam logic [ACC_W-1:0] HALF     = ACC_W'(1) << (LOG2N - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  win_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MOD_W-1:0] peak_q, peak_d;
  logic [ANG_W-1:0] pbrg_q, pbrg_d;

  logic             ov_q, ov_d;
  logic [MOD_W-1:0] avg_q, avg_d;
  logic [MOD_W-1:0] rpeak_q, rpeak_d;
  logic [ANG_W-1:0] rpbrg_q, rpbrg_d;
  logic [ANG_W-1:0] lbrg_q, lbrg_d;

  logic [ANG_W-1:0] bearing;
  logic [MOD_W-1:0] mod_c;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_rnd;
  logic             take;
  logic             new_peak;
  logic [MOD_W-1:0] peak_upd;
  logic [ANG_W-1:0] pbrg_upd;

  wind_bearing_conv u_brg (
    .angle_i   (angle),
    .bearing_o (bearing)
  );

  // Negative modulus means CORDIC overflow; treat it as calm.
  assign mod_c    = mod[MOD_W-1] ? '0 : mod;
  assign take     = in_valid && !clear;
  assign acc_sum  = acc_q + ACC_W'(mod_c);
  assign acc_rnd  = acc_sum + HALF;
  // Strictly greater so ties keep the earliest sample.
  assign new_peak = mod_c > peak_q;
  assign peak_upd = new_peak ? mod_c   : peak_q;
  assign pbrg_upd = new_peak ? bearing : pbrg_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    pbrg_d  = pbrg_q;
    ov_d    = 1'b0;
    avg_d   = avg_q;
    rpeak_d = rpeak_q;
    rpbrg_d = rpbrg_q;
    lbrg_d  = lbrg_q;

    if (clear) begin
      state_d = S_EMPTY;
      acc_d   = '0;
      cnt_d   = '0;
      peak_d  = '0;
      pbrg_d  = '0;
    end else if (take) begin
      lbrg_d = bearing;
      unique case (state_q)
        S_EMPTY: begin
          // Window is at least two samples, so the first never closes it.
          state_d = S_ACCUM;
          acc_d   = ACC_W'(mod_c);
          cnt_d   = CNT_W'(1);
          peak_d  = mod_c;
          pbrg_d  = bearing;
        end
        S_ACCUM: begin
          if (cnt_q == CNT_LAST) begin
            // Closing sample: publish and restart with empty window.
            state_d = S_EMPTY;
            acc_d   = '0;
            cnt_d   = '0;
            peak_d  = '0;
            pbrg_d  = '0;
            ov_d    = 1'b1;
            avg_d   = acc_rnd[ACC_W-1:LOG2N];
            rpeak_d = peak_upd;
            rpbrg_d = pbrg_upd;
          end else begin
            acc_d  = acc_sum;
            cnt_d  = cnt_q + CNT_W'(1);
            peak_d = peak_upd;
            pbrg_d = pbrg_upd;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      peak_q  <= '0;
      pbrg_q  <= '0;
      ov_q    <= 1'b0;
      avg_q   <= '0;
      rpeak_q <= '0;
      rpbrg_q <= '0;
      lbrg_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      pbrg_q  <= pbrg_d;
      ov_q    <= ov_d;
      avg_q   <= avg_d;
      rpeak_q <= rpeak_d;
      rpbrg_q <= rpbrg_d;
      lbrg_q  <= lbrg_d;
    end
  end

  assign out_valid    = ov_q;
  assign avg_mod      = avg_q;
  assign peak_mod     = rpeak_q;
  assign peak_bearing = rpbrg_q;
  assign last_bearing = lbrg_q;

endmodule : wind_polar_stats

// File: doc/wind_polar_stats.md
Name: wind_polar_stats

Overview:
- Sits directly downstream of the wind CORDIC rectangular-to-polar stage and consumes its modulus (6Q10) and angle (signed degrees, 9Q7) results.
- Converts each signed angle to a compass bearing in [0, 360).
- Over a window of 2^LOG2N samples, accumulates modulus to produce a rounded mean wind speed, and tracks the gust: the peak modulus and its bearing.
- Publishes a one-cycle report strobe at the end of each window.

Parameters:
- LOG2N, 4, log2 of window length in samples; legal range 1..8.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous window restart; held outputs are kept.
- in_valid  in  1  one-cycle strobe; mod/angle valid this cycle.
- mod  in  16  signed 6Q10 modulus from CORDIC stage.
- angle  in  16  signed 9Q7 angle in degrees, range [-180, 180].
- out_valid  out  1  one-cycle pulse when a window report is updated.
- avg_mod  out  16  unsigned 6Q10 rounded window mean modulus.
- peak_mod  out  16  unsigned 6Q10 window maximum modulus.
- peak_bearing  out  16  unsigned 9Q7 bearing of the peak sample, [0, 46080).
- last_bearing  out  16  unsigned 9Q7 bearing of the most recent accepted sample.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is `clock`.
- Reset values: all outputs 0 and out_valid 0. FSM in S_EMPTY; accumulator, sample counter and peak registers all 0.
- Bearing conversion: b = (angle < 0) ? angle + 46080 : angle, as an unsigned 16-bit value.
  - angle -23040 (-180°) maps to 23040.
  - angle 0 maps to 0.
  - Positive inputs pass through unchanged.
- Modulus sanitising: negative mod (CORDIC overflow) is clamped to 0 before any use.
- Accumulator: unsigned, 16+LOG2N bits; cannot overflow for any input.
- Mean: avg = (sum + 2^(LOG2N-1)) >> LOG2N, i.e. round half up. The sum includes the final sample of the window.
- Peak selection:
  - The first sample of a window always loads peak and peak bearing.
  - Later samples replace them only if strictly greater; ties keep the earliest sample.
- FSM, two states:
  - S_EMPTY: no samples in the current window. in_valid loads acc = mod, peak = mod, cnt = 1, then moves to S_ACCUM. With LOG2N windows this path always reaches S_ACCUM, since the window is at least 2 samples.
  - S_ACCUM: in_valid adds to acc, updates peak, increments cnt.
  - When cnt reaches 2^LOG2N-1 and in_valid is high (last sample of the window), register the report outputs and return to S_EMPTY.
- Report latency: the last sample accepted at edge t gives out_valid high for exactly the cycle after t. avg_mod, peak_mod and peak_bearing change on the same edge and are held until the next report.
- Back-to-back windows: a sample arriving in the cycle right after the closing sample starts the next window. No dead cycle; in_valid may be high every cycle.
- last_bearing updates on every accepted sample, one cycle after in_valid. It is independent of window state.
- clear:
  - Zeroes acc, cnt and peak registers and forces S_EMPTY.
  - Does not alter avg_mod, peak_mod, peak_bearing or last_bearing.
  - Suppresses any out_valid for that edge.
- clear and in_valid in the same cycle: clear wins and the sample is discarded, including for last_bearing.
- reset while a window is in progress: partial data is lost and outputs return to 0.
- in_valid high during reset: ignored.

Decomposition:
- Package wind_pkg holds:
  - DEG360_Q7 = 46080 and DEG180_Q7 = 23040.
  - Q-format widths: MOD_W = 16, ANG_W = 16, MOD_FRAC = 10, ANG_FRAC = 7.
  - FSM state encoding: S_EMPTY, S_ACCUM.
- One sub-module, wind_bearing_conv: combinational signed-angle to unsigned-bearing conversion. It is instantiated once and feeds both last_bearing and the peak-bearing candidate.

Test Plan:
1. Reset asserted for 3 cycles with in_valid toggling -> all outputs 0, out_valid never high, no window progress.
2. LOG2N=2, consecutive samples mod = 1024, 2048, 3072, 4096 with angle 0 -> out_valid one cycle after the 4th sample. Expected avg_mod = 2560, peak_mod = 4096, peak_bearing = 0.
3. Bearing conversion: angle -11520 -> last_bearing 34560; angle -23040 -> 23040; angle 23039 -> 23039; angle 0 -> 0.
4. LOG2N=2, tie and clamp: mods 5000@1280, 5000@2560, -5@0, 100@0 -> peak_mod 5000 and peak_bearing 1280. Expected avg_mod = (10100 + 2) >> 2 = 2525, since -5 is clamped to 0.
5. Clear behaviour, LOG2N=2:
   - 2 samples of 8000, then clear asserted together with a 9000 sample -> 9000 sample discarded.
   - Then 4 samples of 1024 -> single out_valid with avg_mod 1024 and peak_mod 1024.
   - last_bearing reflects only the accepted samples.
6. LOG2N=4, in_valid high for 32 consecutive cycles with mod ramp 0..31 -> out_valid pulses exactly 16 cycles apart. Expected first avg_mod = (120 + 8) >> 4 = 8 with peak 15; second avg_mod = (376 + 8) >> 4 = 24 with peak 31.
